// File: rtl/apple_spawn_ctrl.sv
// Apple spawn controller for the snake game.
// Watches head-position strobes and detects when the head lands on a shown
// apple. It then hides that apple, emits one body-grow pulse, and respawns the
// apple at a free, legal position drawn from a free-running LFSR.
//
// Handshake: Head_vld is a one-cycle strobe with no back-pressure (no ready).
// A strobe is acted on only while the controller is idle (Busy=0). Strobes
// that arrive while Busy=1 are dropped without any effect.
module apple_spawn_ctrl #(
  parameter int                           N_APPLE     = 3,
  parameter int                           COORD_W     = 4,
  parameter int                           X_MAX       = 15,
  parameter int                           Y_MAX       = 15,
  parameter logic [N_APPLE*2*COORD_W-1:0] INIT_APPLES = 24'hA8_6A_58,
  parameter logic [15:0]                  LFSR_SEED   = 16'hACE1
) (
  input  logic                           Clk_24mhz,
  input  logic                           Rst_n,
  input  logic [2*COORD_W-1:0]           Head,
  input  logic                           Head_vld,
  output logic [N_APPLE*2*COORD_W-1:0]   Apples,
  output logic [N_APPLE-1:0]             Apple_vld,
  output logic                           Body_add_sig,
  output logic                           Busy,
  output logic [15:0]                    Eat_cnt
);

  localparam int                 PW    = 2 * COORD_W;
  localparam int                 IDX_W = (N_APPLE > 1) ? $clog2(N_APPLE) : 1;
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  typedef enum logic [0:0] {IDLE, SPAWN} state_t;

  state_t             state_q, state_d;
  logic [15:0]        lfsr;
  logic [IDX_W-1:0]   idx_q;
  logic [PW-1:0]      head_q;
  logic [PW-1:0]      cand;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic               hit, coll, accept, eat, spawn_ok;
  logic [IDX_W-1:0]   hit_idx;

  assign cand_x = lfsr[PW-1:COORD_W];
  assign cand_y = lfsr[COORD_W-1:0];
  assign cand   = {cand_x, cand_y};
  assign Busy   = (state_q == SPAWN);

  // Free-running Galois LFSR (x^16+x^14+x^13+x^11+1); it never pauses.
  always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
    if (!Rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // Head-vs-apple compare; scanning downward leaves the lowest matching slot.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_APPLE - 1; k >= 0; k--) begin
      if (Apple_vld[k] && (Apples[k*PW +: PW] == Head)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Candidate acceptance. The slot being respawned is already invalid, so
  // checking every valid slot excludes only the other apples.
  always_comb begin
    coll = 1'b0;
    for (int k = 0; k < N_APPLE; k++) begin
      if (Apple_vld[k] && (Apples[k*PW +: PW] == cand)) coll = 1'b1;
    end
    accept = (cand_x != '0) && (cand_x <= X_LIM) &&
             (cand_y != '0) && (cand_y <= Y_LIM) &&
             (cand != head_q) && !coll;
  end

  // FSM state register.
  always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state and event decode.
  always_comb begin
    state_d  = state_q;
    eat      = 1'b0;
    spawn_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (Head_vld && hit) begin
          eat     = 1'b1;
          state_d = SPAWN;
        end
      end
      SPAWN: begin
        if (accept) begin
          spawn_ok = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Apple slots, eat pulse, latched head/index and saturating eat counter.
  always_ff @(posedge Clk_24mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      Apples       <= INIT_APPLES;
      Apple_vld    <= '1;
      Body_add_sig <= 1'b0;
      Eat_cnt      <= 16'h0000;
      idx_q        <= '0;
      head_q       <= '0;
    end else begin
      Body_add_sig <= eat;
      if (eat) begin
        idx_q  <= hit_idx;
        head_q <= Head;
        if (Eat_cnt != 16'hFFFF) Eat_cnt <= Eat_cnt + 16'd1;
      end
      for (int k = 0; k < N_APPLE; k++) begin
        if (eat && (hit_idx == IDX_W'(k))) Apple_vld[k] <= 1'b0;
        if (spawn_ok && (idx_q == IDX_W'(k))) begin
          Apples[k*PW +: PW] <= cand;
          Apple_vld[k]       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Bench for apple_spawn_ctrl: default instance with exact respawn prediction,
// a duplicate-slot instance, and a 3x3 board instance for a long soak.
module tb_apple_spawn_ctrl;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [23:0] INIT_A = 24'hA8_6A_58;
  localparam logic [23:0] INIT_B = 24'hA8_77_77;
  localparam logic [11:0] INIT_C = {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  head_a, head_b;
  logic [3:0]  head_c;
  logic        vld_a, vld_b, vld_c;
  logic [23:0] apples_a, apples_b;
  logic [11:0] apples_c;
  logic [2:0]  avld_a, avld_b, avld_c;
  logic        pulse_a, pulse_b, pulse_c;
  logic        busy_a, busy_b, busy_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  apple_spawn_ctrl dut_a (
    .Clk_24mhz(clk), .Rst_n(rst_n), .Head(head_a), .Head_vld(vld_a),
    .Apples(apples_a), .Apple_vld(avld_a), .Body_add_sig(pulse_a),
    .Busy(busy_a), .Eat_cnt(cnt_a));

  apple_spawn_ctrl #(.INIT_APPLES(INIT_B)) dut_b (
    .Clk_24mhz(clk), .Rst_n(rst_n), .Head(head_b), .Head_vld(vld_b),
    .Apples(apples_b), .Apple_vld(avld_b), .Body_add_sig(pulse_b),
    .Busy(busy_b), .Eat_cnt(cnt_b));

  apple_spawn_ctrl #(.COORD_W(2), .X_MAX(3), .Y_MAX(3), .INIT_APPLES(INIT_C)) dut_c (
    .Clk_24mhz(clk), .Rst_n(rst_n), .Head(head_c), .Head_vld(vld_c),
    .Apples(apples_c), .Apple_vld(avld_c), .Body_add_sig(pulse_c),
    .Busy(busy_c), .Eat_cnt(cnt_c));

  // Reference model state
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  ma [3];
  logic [2:0]  mv;
  int          exp_cnt;
  logic [3:0]  mc [3];

  // Reference random sequence: the specified Galois LFSR, stepped every cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack_a();
    return {ma[2], ma[1], ma[0]};
  endfunction

  function automatic bit hit_any(input logic [7:0] h);
    bit r = 0;
    for (int k = 0; k < 3; k++) if (mv[k] && ma[k] == h) r = 1;
    return r;
  endfunction

  // Legal spawn spot on the 15x15 board, away from the head and live apples.
  function automatic bit legal_a(input logic [7:0] c, input logic [7:0] h);
    int x = int'(c[7:4]);
    int y = int'(c[3:0]);
    return (x >= 1) && (x <= 15) && (y >= 1) && (y <= 15) && (c != h) && !hit_any(c);
  endfunction

  task automatic model_reset();
    ma[0] = 8'h58; ma[1] = 8'h6A; ma[2] = 8'hA8;
    mv = 3'b111;
    exp_cnt = 0;
    mc[0] = 4'b0101; mc[1] = 4'b1010; mc[2] = 4'b1111;
  endtask

  task automatic check_reset();
    check("rst_apples_a", apples_a, INIT_A);
    check("rst_vld_a", avld_a, 3'b111);
    check("rst_pulse_a", pulse_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_apples_b", apples_b, INIT_B);
    check("rst_apples_c", apples_c, INIT_C);
    check("rst_busy_c", busy_c, 0);
    check("rst_cnt_c", cnt_c, 0);
  endtask

  // Driver for dut_a: one head strobe, then cycle-by-cycle respawn prediction.
  task automatic eat_a(input logic [7:0] h);
    int idx;
    logic [7:0] cand;
    bit ok, done;
    idx = -1;
    for (int k = 2; k >= 0; k--) if (mv[k] && ma[k] == h) idx = k;
    head_a = h; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    if (idx < 0) begin
      check("miss_pulse", pulse_a, 0);
      check("miss_busy", busy_a, 0);
      check("miss_apples", apples_a, pack_a());
      check("miss_vld", avld_a, mv);
      check("miss_cnt", cnt_a, exp_cnt);
      return;
    end
    mv[idx] = 1'b0;
    if (exp_cnt != 32'hFFFF) exp_cnt++;
    check("eat_pulse", pulse_a, 1);
    check("eat_busy", busy_a, 1);
    check("eat_vld", avld_a, mv);
    check("eat_cnt", cnt_a, exp_cnt);
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      cand = m_lfsr[7:0];
      ok = legal_a(cand, h);
      head_a = 8'($urandom);
      vld_a  = 1'($urandom_range(0, 1));
      @(negedge clk);
      vld_a = 1'b0;
      if (ok) begin ma[idx] = cand; mv[idx] = 1'b1; done = 1; end
      check("spawn_pulse", pulse_a, 0);
      check("spawn_busy", busy_a, !done);
      check("spawn_vld", avld_a, mv);
      check("spawn_apples", apples_a, pack_a());
      check("spawn_cnt", cnt_a, exp_cnt);
    end
    if (!done) check("spawn_timeout", busy_a, 0);
  endtask

  initial begin
    logic [7:0] h, s0;
    logic [3:0] h4, nw;
    int k;
    bit ok_c;

    head_a = '0; head_b = '0; head_c = '0;
    vld_a = 0; vld_b = 0; vld_c = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1;
    @(negedge clk);

    // First eat of slot 0 with exact respawn position and 2-cycle latency.
    eat_a(8'h58);
    s0 = apples_a[7:0];
    check("first_spawn_fresh", (s0 != 8'h58) && (s0 != 8'h6A) && (s0 != 8'hA8), 1);

    // Head on an empty square.
    h = 8'h33;
    while (hit_any(h)) h = h + 8'h01;
    eat_a(h);
    repeat (2) @(negedge clk);
    check("miss_quiet_pulse", pulse_a, 0);
    check("miss_quiet_apples", apples_a, pack_a());

    // Random eats and misses.
    repeat (16) begin
      if ($urandom_range(0, 3) == 0) h = 8'($urandom);
      else h = ma[$urandom_range(0, 2)];
      eat_a(h);
    end

    // Duplicate slots: only the lowest index is eaten.
    head_b = 8'h77; vld_b = 1;
    @(negedge clk);
    vld_b = 0;
    check("dup_pulse", pulse_b, 1);
    check("dup_vld", avld_b, 3'b110);
    check("dup_busy", busy_b, 1);
    for (int c = 0; c < 64 && busy_b; c++) @(negedge clk);
    check("dup_done", busy_b, 0);
    check("dup_vld_after", avld_b, 3'b111);
    check("dup_slot1", apples_b[15:8], 8'h77);
    check("dup_slot2", apples_b[23:16], 8'hA8);
    s0 = apples_b[7:0];
    check("dup_slot0_legal",
          (s0[7:4] != 0) && (s0[3:0] != 0) && (s0 != 8'h77) && (s0 != 8'hA8), 1);
    check("dup_cnt", cnt_b, 1);

    // 3x3 board soak.
    for (int i = 0; i < 10000 && n_fail == 0; i++) begin
      k = $urandom_range(0, 2);
      h4 = mc[k];
      head_c = h4; vld_c = 1;
      @(negedge clk);
      vld_c = 0;
      check("c_pulse", pulse_c, 1);
      for (int c = 0; c < 200 && busy_c; c++) @(negedge clk);
      check("c_done", busy_c, 0);
      check("c_vld", avld_c, 3'b111);
      nw = apples_c[k*4 +: 4];
      ok_c = (nw[3:2] != 0) && (nw[1:0] != 0) && (nw != h4);
      for (int j = 0; j < 3; j++) if (j != k && nw == mc[j]) ok_c = 0;
      check("c_legal", ok_c, 1);
      mc[k] = nw;
      check("c_apples", apples_c, {mc[2], mc[1], mc[0]});
    end
    check("c_cnt", cnt_c, 10000);

    // Asynchronous reset while a respawn is in progress.
    head_a = ma[0]; vld_a = 1;
    @(negedge clk);
    vld_a = 0;
    check("mid_busy", busy_a, 1);
    #2 rst_n = 0;
    #1 check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Counter saturation from a preloaded value.
    force dut_a.Eat_cnt = 16'hFFFE;
    #1 release dut_a.Eat_cnt;
    exp_cnt = 32'hFFFE;
    check("sat_preload", cnt_a, exp_cnt);
    @(negedge clk);
    repeat (3) eat_a(ma[$urandom_range(0, 2)]);
    check("sat_final", cnt_a, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apple_spawn_ctrl.md
APPLE_SPAWN_CTRL -- requirements
Module: apple_spawn_ctrl

Interface
REQ-001 SHALL have parameter N_APPLE, default 3, number of apple slots (1..8).
REQ-002 SHALL have parameter COORD_W, default 4, bits per X or Y coordinate (2..8).
REQ-003 SHALL have parameter X_MAX, default 15, largest legal X; legal X range is 1..X_MAX.
REQ-004 SHALL have parameter Y_MAX, default 15, largest legal Y; legal Y range is 1..Y_MAX.
REQ-005 SHALL have parameter INIT_APPLES, default {X=10,Y=8},{X=6,Y=10},{X=5,Y=8}; slot2..slot0 reset positions, each packed {X,Y}.
REQ-006 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 SHALL have port Clk_24mhz, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port Head, input, 2*COORD_W, snake head, packed {X,Y}.
REQ-010 SHALL have port Head_vld, input, 1, one-cycle strobe: Head holds a new position.
REQ-011 SHALL have port Apples, output, N_APPLE*2*COORD_W, slot k at bits [k*2*COORD_W +: 2*COORD_W], packed {X,Y}.
REQ-012 SHALL have port Apple_vld, output, N_APPLE, slot k displayed when bit k = 1.
REQ-013 SHALL have port Body_add_sig, output, 1, one-cycle pulse per apple eaten.
REQ-014 SHALL have port Busy, output, 1, high while a respawn is in progress.
REQ-015 SHALL have port Eat_cnt, output, 16, total apples eaten, saturating.

Function
REQ-016 SHALL run a 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400) that advances every cycle regardless of state.
REQ-017 SHALL form the candidate from the current LFSR value: X = lfsr[2*COORD_W-1:COORD_W], Y = lfsr[COORD_W-1:0]; 2*COORD_W <= 16 is required.
REQ-018 SHALL implement FSM states IDLE, SPAWN.
REQ-019 In IDLE with Head_vld=1, SHALL compare Head against every slot with Apple_vld=1.
REQ-020 On a match, SHALL select the lowest matching index i, pulse Body_add_sig on the next cycle, clear Apple_vld[i], latch i, and enter SPAWN.
REQ-021 With no match, SHALL remain in IDLE with Body_add_sig=0.
REQ-022 Head_vld while in SPAWN SHALL be ignored: no compare and no pulse.
REQ-023 In SPAWN, each cycle SHALL accept the candidate only if all hold: 1<=X<=X_MAX; 1<=Y<=Y_MAX; candidate != latched Head; candidate != any other valid slot.
REQ-024 On accept, SHALL write Apples[i]=candidate, set Apple_vld[i]=1, and return to IDLE in the same edge.
REQ-025 On reject, SHALL retry with the next LFSR value on the next cycle; there is no retry cap.
REQ-026 Busy SHALL equal (state == SPAWN).
REQ-027 Eat_cnt SHALL increment by 1 with each Body_add_sig pulse and hold at 16'hFFFF.
REQ-028 Head SHALL be latched at the Head_vld that caused the eat; later changes to Head SHALL NOT affect the exclusion check.
REQ-029 Slots other than i SHALL never change outside reset.
REQ-030 Minimum latency from an eating Head_vld to Apple_vld[i]=1 SHALL be 2 cycles.

Reset
REQ-031 While Rst_n=0, SHALL set: state=IDLE; Apples=INIT_APPLES; Apple_vld=all ones; Body_add_sig=0; Busy=0; Eat_cnt=0; lfsr=LFSR_SEED.
REQ-032 Reset asserted mid-SPAWN SHALL abort the respawn immediately and restore all REQ-031 values.
REQ-033 After Rst_n deasserts, SHALL resume normal operation on the first rising edge.

Verification
REQ-034 Reset, then Head={5,8} with Head_vld -> Body_add_sig pulses once, Apple_vld=3'b110, then Busy=1, then Apple_vld[0]=1 at a legal position not in {{5,8},{6,10},{10,8}}, and Eat_cnt=1.
REQ-035 Head={3,3} with Head_vld -> no pulse, Apples unchanged, Busy=0.
REQ-036 Force slots 0 and 1 to {7,7}, then Head={7,7} with Head_vld -> only slot 0 respawns and slot 1 stays {7,7}.
REQ-037 X_MAX=Y_MAX=3 with N_APPLE=3, run 10000 eats -> every spawned apple lies within 1..3, avoids the head, never duplicates a slot, and no FSM hang.
REQ-038 Assert Rst_n=0 while Busy=1 -> outputs match REQ-031 within the same cycle (asynchronous).
REQ-039 Preload Eat_cnt to 16'hFFFE, perform 3 eats -> Eat_cnt saturates at 16'hFFFF.
